// File: rtl/ctrl_pkg.sv
// Shared decode-stage control types: opcodes, functs, field encodings
// and the ID/EX control bundle.
package ctrl_pkg;

  localparam int NB_OP    = 6;
  localparam int NB_REG   = 5;
  localparam int NB_ALUOP = 3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_LWU   = 6'h27;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_RTYPE, ALU_AND,
    ALU_OR, ALU_XOR, ALU_LUI, ALU_SLT
  } alu_op_e;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10
  } ext_e;

  typedef enum logic [1:0] {
    DST_RT  = 2'b00,
    DST_RD  = 2'b01,
    DST_R31 = 2'b10
  } dst_e;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b11
  } width_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } br_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_TGT  = 2'b01,
    JMP_REG  = 2'b10
  } jmp_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    ext_e    ext_mode;
    dst_e    reg_dst;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    width_e  mem_width;
    logic    mem_unsigned;
    br_e     branch;
    jmp_e    jump;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // Load/store opcodes encode access size in their two low bits
  function automatic width_e mem_width_f(
    input logic [NB_OP-1:0] op
  );
    unique case (1'b1)
      (op[1:0] == 2'b11): return W_WORD;
      op[0]:              return W_HALF;
      default:            return W_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/decode_control_pipe_if.sv
// Decode-stage control bus: IF/ID instruction fields and hazard
// inputs in, registered ID/EX control bundle and stall out.
interface decode_control_pipe_if;
  import ctrl_pkg::*;

  logic              i_valid;
  logic [NB_OP-1:0]  i_opcode;
  logic [NB_OP-1:0]  i_funct;
  logic [NB_REG-1:0] i_rs;
  logic [NB_REG-1:0] i_rt;
  logic              i_ex_mem_read;
  logic [NB_REG-1:0] i_ex_rt;
  logic              i_flush;

  logic                o_stall;
  logic                o_valid;
  logic [NB_ALUOP-1:0] o_alu_op;
  logic                o_alu_src;
  logic [1:0]          o_ext_mode;
  logic [1:0]          o_reg_dst;
  logic                o_reg_write;
  logic                o_mem_read;
  logic                o_mem_write;
  logic                o_mem_to_reg;
  logic [1:0]          o_mem_width;
  logic                o_mem_unsigned;
  logic [1:0]          o_branch;
  logic [1:0]          o_jump;
  logic                o_illegal;

  modport master (
    output i_valid, i_opcode, i_funct, i_rs, i_rt,
    output i_ex_mem_read, i_ex_rt, i_flush,
    input  o_stall, o_valid, o_alu_op, o_alu_src,
    input  o_ext_mode, o_reg_dst, o_reg_write,
    input  o_mem_read, o_mem_write, o_mem_to_reg,
    input  o_mem_width, o_mem_unsigned, o_branch,
    input  o_jump, o_illegal
  );

  modport slave (
    input  i_valid, i_opcode, i_funct, i_rs, i_rt,
    input  i_ex_mem_read, i_ex_rt, i_flush,
    output o_stall, o_valid, o_alu_op, o_alu_src,
    output o_ext_mode, o_reg_dst, o_reg_write,
    output o_mem_read, o_mem_write, o_mem_to_reg,
    output o_mem_width, o_mem_unsigned, o_branch,
    output o_jump, o_illegal
  );

endinterface

// File: rtl/ctrl_decoder.sv
// Combinational opcode/funct -> control bundle lookup, with
// illegal-encoding and rt-is-a-source flags.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [NB_OP-1:0] opcode,
  input  logic [NB_OP-1:0] funct,
  output ctrl_t            ctrl,
  output logic             illegal,
  output logic             rt_src
);

  always_comb begin
    ctrl    = BUBBLE;
    illegal = 1'b0;
    rt_src  = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        rt_src         = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
        ctrl.reg_dst   = DST_RD;
        ctrl.reg_write = 1'b1;
        unique case (funct)
          FN_JR: begin
            ctrl.jump      = JMP_REG;
            ctrl.reg_write = 1'b0;
          end
          FN_JALR: ctrl.jump = JMP_REG;
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV,
          FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU,
          FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: ;
          default: illegal = 1'b1;
        endcase
      end
      OP_J: ctrl.jump = JMP_TGT;
      OP_JAL: begin
        ctrl.jump      = JMP_TGT;
        ctrl.reg_dst   = DST_R31;
        ctrl.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        rt_src      = 1'b1;
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = opcode[0] ? BR_NE : BR_EQ;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        unique case (opcode)
          OP_SLTI, OP_SLTIU: ctrl.alu_op = ALU_SLT;
          OP_ANDI: begin
            ctrl.alu_op   = ALU_AND;
            ctrl.ext_mode = EXT_ZERO;
          end
          OP_ORI: begin
            ctrl.alu_op   = ALU_OR;
            ctrl.ext_mode = EXT_ZERO;
          end
          OP_XORI: begin
            ctrl.alu_op   = ALU_XOR;
            ctrl.ext_mode = EXT_ZERO;
          end
          OP_LUI: begin
            ctrl.alu_op   = ALU_LUI;
            ctrl.ext_mode = EXT_UPPER;
          end
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_LB, OP_LH, OP_LW,
      OP_LBU, OP_LHU, OP_LWU: begin
        ctrl.alu_src      = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.mem_to_reg   = 1'b1;
        ctrl.reg_write    = 1'b1;
        ctrl.mem_width    = mem_width_f(opcode);
        ctrl.mem_unsigned = opcode[2];
      end
      OP_SB, OP_SH, OP_SW: begin
        rt_src         = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.mem_width = mem_width_f(opcode);
      end
      default: illegal = 1'b1;
    endcase
    // Unsupported encodings must never write or redirect anything
    if (illegal) begin
      ctrl   = BUBBLE;
      rt_src = 1'b0;
    end
  end

endmodule

// File: rtl/decode_control_pipe.sv
// Decode-stage main control: hazard detect, flush/bubble priority and
// ID/EX control register. Optional trap flag: CTRL_ILLEGAL_TRAP_EN.
module decode_control_pipe
  import ctrl_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  decode_control_pipe_if.slave  bus
);

  ctrl_t dec;
  ctrl_t ctrl_q;
  logic  illegal;
  logic  rt_src;
  logic  hazard;
  logic  bubble;
  logic  valid_q;

  ctrl_decoder u_dec (
    .opcode  (bus.i_opcode),
    .funct   (bus.i_funct),
    .ctrl    (dec),
    .illegal (illegal),
    .rt_src  (rt_src)
  );

  assign hazard = bus.i_valid & bus.i_ex_mem_read
                & (bus.i_ex_rt != '0)
                & ((bus.i_ex_rt == bus.i_rs)
                 | (rt_src & (bus.i_ex_rt == bus.i_rt)));

  // Flush wins: the bubble it loads also clears the hazard
  assign bubble      = bus.i_flush | ~bus.i_valid | hazard;
  assign bus.o_stall = hazard & ~bus.i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q  <= BUBBLE;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= bubble ? BUBBLE : dec;
      valid_q <= ~bubble;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) illegal_q <= 1'b0;
    else          illegal_q <= ~bubble & illegal;
  end

  assign bus.o_illegal = illegal_q;
`else
  logic illegal_unused;

  assign illegal_unused = illegal;
  assign bus.o_illegal  = 1'b0;
`endif

  assign bus.o_valid        = valid_q;
  assign bus.o_alu_op       = ctrl_q.alu_op;
  assign bus.o_alu_src      = ctrl_q.alu_src;
  assign bus.o_ext_mode     = ctrl_q.ext_mode;
  assign bus.o_reg_dst      = ctrl_q.reg_dst;
  assign bus.o_reg_write    = ctrl_q.reg_write;
  assign bus.o_mem_read     = ctrl_q.mem_read;
  assign bus.o_mem_write    = ctrl_q.mem_write;
  assign bus.o_mem_to_reg   = ctrl_q.mem_to_reg;
  assign bus.o_mem_width    = ctrl_q.mem_width;
  assign bus.o_mem_unsigned = ctrl_q.mem_unsigned;
  assign bus.o_branch       = ctrl_q.branch;
  assign bus.o_jump         = ctrl_q.jump;

endmodule
